// File: rtl/ssio_sdr_out_div.sv
// rtl/ssio_sdr_out_div.sv - source-synchronous SDR output stage with divided forwarded clock
//
// Purpose:
//   Takes words from a valid/ready stream in the clk domain and forwards a
//   clock at clk/CLK_DIV on output_clk. Each word is launched on the cycle
//   where output_clk falls, so the far-end receiver samples on the following
//   rising edge, centred in the data eye. Every pad-facing output comes
//   straight from a flop, so the output registers can be packed into the IOB.
//
// Parameters:
//   WIDTH           data lane width
//   CLK_DIV         forwarded clock divide ratio, even and >= 2
//   IDLE_VALUE      value on output_q when no word is launched
//   IDLE_STOP_BEATS idle launches before the clock stops (1..255, clock-stop build only)
//
// Ports:
//   clk         logic clock, all state updates on its rising edge
//   rst_n       synchronous active-low reset
//   s_data      word to transmit
//   s_valid     s_data is valid
//   s_ready     word is accepted this cycle when s_valid is also high
//   output_clk  forwarded clock (register)
//   output_q    launched data (register)
//   output_en   output_q carries an accepted word (register)
//
// Build option:
//   SSIO_SDR_OUT_CLK_STOP_EN - adds a RUN/STOP FSM that parks output_clk low
//   after IDLE_STOP_BEATS consecutive idle launches and restarts on the next
//   accepted word. Undefined: the forwarded clock runs freely from reset.

module ssio_sdr_out_div #(
  parameter int               WIDTH           = 8,
  parameter int               CLK_DIV         = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE      = '0,
  parameter int               IDLE_STOP_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             output_clk,
  output logic [WIDTH-1:0] output_q,
  output logic             output_en
);

  localparam int            HALF     = CLK_DIV / 2;
  localparam int            CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 ||
      IDLE_STOP_BEATS < 1 || IDLE_STOP_BEATS > 255) begin : g_param_check
    $error("ssio_sdr_out_div: CLK_DIV must be even >= 2, IDLE_STOP_BEATS 1..255");
  end

  logic [CW-1:0]    cnt;
  logic             clk_q;
  logic             full;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] q_r;
  logic             en_r;

  logic running;
  logic launch;
  logic accept;

  // Falling-edge cycle of the forwarded clock: the last half-period count
  // while the clock is high.
  assign launch = running && (cnt == CNT_LAST) && clk_q;

  // Ready is a function of state and reset only; a launch frees the hold
  // register in the same cycle, so a back-to-back word can be taken then.
  assign s_ready = rst_n && (!full || launch);
  assign accept  = s_valid && s_ready;

`ifdef SSIO_SDR_OUT_CLK_STOP_EN
  typedef enum logic {
    ST_RUN,
    ST_STOP
  } state_t;

  localparam logic [7:0] STOP_BEATS = 8'(IDLE_STOP_BEATS);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] idle_cnt;
  logic [7:0] idle_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      idle_cnt <= '0;
    end else begin
      state_q  <= state_d;
      idle_cnt <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt;
    case (state_q)
      ST_RUN: begin
        if (launch) begin
          if (full) begin
            idle_cnt_d = '0;
          end else begin
            if (idle_cnt != 8'hFF) begin
              idle_cnt_d = idle_cnt + 8'd1;
            end
            // A word accepted on the stopping launch keeps the clock running,
            // otherwise it would sit in the hold register with no clock.
            if (idle_cnt_d >= STOP_BEATS && !accept) begin
              state_d    = ST_STOP;
              idle_cnt_d = '0;
            end
          end
        end
      end
      ST_STOP: begin
        if (accept) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
      end
    endcase
  end

  assign running = (state_q == ST_RUN);
`else
  assign running = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      clk_q <= 1'b0;
      full  <= 1'b0;
      hold  <= IDLE_VALUE;
      q_r   <= IDLE_VALUE;
      en_r  <= 1'b0;
    end else begin
      // Half-period divider; parked at phase zero while stopped so a restart
      // has the same timing as leaving reset.
      if (!running) begin
        cnt   <= '0;
        clk_q <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        clk_q <= ~clk_q;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (launch) begin
        q_r  <= full ? hold : IDLE_VALUE;
        en_r <= full;
      end else if (!running) begin
        q_r  <= IDLE_VALUE;
        en_r <= 1'b0;
      end

      // Accept wins over the launch clear: the old word has just been copied
      // to q_r, the new one takes its place in the hold register.
      if (accept) begin
        hold <= s_data;
        full <= 1'b1;
      end else if (launch) begin
        full <= 1'b0;
      end
    end
  end

  assign output_clk = clk_q;
  assign output_q   = q_r;
  assign output_en  = en_r;

endmodule

// File: tb/tb_ssio_sdr_out_div.sv
// tb/tb_ssio_sdr_out_div.sv - self-checking bench for ssio_sdr_out_div
module tb_ssio_sdr_out_div;

  localparam int         CLK_DIV = 4;
  localparam int         HALF    = CLK_DIV / 2;
  localparam logic [7:0] IDLE    = 8'h00;
`ifdef SSIO_SDR_OUT_CLK_STOP_EN
  localparam int STOP_N  = 2;
  localparam bit STOP_ON = 1'b1;
`else
  localparam int STOP_N  = 4;
  localparam bit STOP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       output_clk;
  logic [7:0] output_q;
  logic       output_en;

  ssio_sdr_out_div #(
    .WIDTH(8),
    .CLK_DIV(CLK_DIV),
    .IDLE_VALUE(IDLE),
    .IDLE_STOP_BEATS(STOP_N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .output_clk(output_clk),
    .output_q(output_q),
    .output_en(output_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // Reference model: edges since the clock (re)started, a FIFO of accepted
  // words, and the last launched value.
  int         e = 0;
  logic [7:0] mq[$];
  logic [7:0] m_q = IDLE;
  bit         m_en = 1'b0;
  bit         m_stop = 1'b0;
  int         m_idle = 0;
  bit         m_launch = 1'b0;
  bit         smp_ready;
  bit         last_acc;

  function automatic bit m_ready(input bit rst);
    return rst && (m_stop || mq.size() == 0 || ((e + 1) % CLK_DIV == 0));
  endfunction

  function automatic bit m_clk();
    return m_stop ? 1'b0 : bit'((e / HALF) % 2);
  endfunction

  function automatic void m_update(input bit rst, input bit acc, input logic [7:0] d);
    m_launch = 1'b0;
    if (!rst) begin
      e = 0; mq.delete(); m_q = IDLE; m_en = 1'b0; m_stop = 1'b0; m_idle = 0;
    end else if (m_stop) begin
      if (acc) begin
        mq.push_back(d); m_stop = 1'b0; e = 0;
      end
    end else begin
      e++;
      if (e % CLK_DIV == 0) begin
        m_launch = 1'b1;
        if (mq.size() > 0) begin
          m_q = mq.pop_front(); m_en = 1'b1; m_idle = 0;
        end else begin
          m_q = IDLE; m_en = 1'b0; m_idle++;
          if (STOP_ON && m_idle >= STOP_N && !acc) begin
            m_stop = 1'b1; e = 0; m_idle = 0;
          end
        end
      end
      if (acc) mq.push_back(d);
    end
  endfunction

  task automatic cycle(input bit rst, input bit vld, input logic [7:0] d);
    rst_n = rst; s_valid = vld; s_data = d;
    #1;
    smp_ready = s_ready;
    chk("s_ready", s_ready, m_ready(rst));
    last_acc = vld && m_ready(rst);
    @(posedge clk);
    m_update(rst, last_acc, d);
    #1;
    chk("output_clk", output_clk, m_clk());
    chk("output_q", output_q, m_q);
    chk("output_en", output_en, m_en);
  endtask

  typedef struct {
    bit         rst;
    bit         vld;
    logic [7:0] d;
    bit         r;
    bit         c;
    logic [7:0] q;
    bit         en;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] log_q[$];

  initial begin
    bit         ok;
    int         gaps;
    int         seen;
    logic [7:0] d;

    // reset then four free-running edges, reset again, then a single word
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0});

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].vld, tbl[i].d);
      chk($sformatf("tbl%0d_ready", i), smp_ready, tbl[i].r);
      chk($sformatf("tbl%0d_clk", i), output_clk, tbl[i].c);
      chk($sformatf("tbl%0d_q", i), output_q, tbl[i].q);
      chk($sformatf("tbl%0d_en", i), output_en, tbl[i].en);
    end

    // streaming 0x01..0x08 with s_valid held
    cycle(1'b0, 1'b0, 8'h00);
    d = 8'h01; gaps = 0; log_q.delete();
    for (int i = 0; i < 50; i++) begin
      if (d <= 8'h08) cycle(1'b1, 1'b1, d);
      else cycle(1'b1, 1'b0, 8'h00);
      if (last_acc) d++;
      if (m_launch && output_en) log_q.push_back(output_q);
      else if (m_launch && log_q.size() > 0 && log_q.size() < 8) gaps++;
    end
    chk("stream_accepted", d, 8'h09);
    chk("stream_count", log_q.size(), 8);
    foreach (log_q[k]) chk("stream_word", log_q[k], k + 1);
    chk("stream_gaps", gaps, 0);

    // backpressure and accept in the launch cycle
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(1'b1, 1'b1, 8'h11);
      ok = last_acc;
    end
    chk("bp_fill", ok, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(1'b1, 1'b1, 8'h3C);
      ok = last_acc;
    end
    chk("bp_accept", ok, 1'b1);
    chk("bp_launch_old_q", output_q, 8'h11);
    chk("bp_launch_old_en", output_en, 1'b1);
    chk("bp_launch_clk", output_clk, 1'b0);
    for (int i = 0; i < CLK_DIV - 1; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      chk("bp_hold_old", output_q, 8'h11);
    end
    cycle(1'b1, 1'b0, 8'h00);
    chk("bp_new_word", output_q, 8'h3C);
    chk("bp_new_en", output_en, 1'b1);

    // reset while a word is on the pins and another is held
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h21);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(1'b1, 1'b1, 8'h22);
      ok = last_acc;
    end
    chk("rm_fill", ok, 1'b1);
    chk("rm_pre_q", output_q, 8'h21);
    chk("rm_pre_en", output_en, 1'b1);
    cycle(1'b0, 1'b0, 8'h00);
    chk("rm_q", output_q, IDLE);
    chk("rm_en", output_en, 1'b0);
    chk("rm_clk", output_clk, 1'b0);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      if (output_q == 8'h22 || output_en) seen++;
    end
    chk("rm_never_seen", seen, 0);

`ifdef SSIO_SDR_OUT_CLK_STOP_EN
    // clock stop after two idle launches, restart on accept
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      chk("stop_clk", output_clk, 1'b0);
      chk("stop_ready", smp_ready, 1'b1);
    end
    cycle(1'b1, 1'b1, 8'h5A);
    chk("restart_accept", smp_ready, 1'b1);
    chk("restart_clk0", output_clk, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("restart_clk1", output_clk, 1'b0);
    cycle(1'b1, 1'b0, 8'h00);
    chk("restart_clk2", output_clk, 1'b1);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    chk("restart_q", output_q, 8'h5A);
    chk("restart_en", output_en, 1'b1);
    chk("restart_fall", output_clk, 1'b0);
`endif

    // randomized traffic with varying density and occasional reset
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = int'($urandom_range(0, 4));
      for (int i = 0; i < 50; i++) begin
        cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) < dens), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
